axi_core_master: RTL and testbench

- Upstream neighbour of the AXI SRAM slave. Converts a simple core memory port (req/we/addr/wdata/wstrb) into single-beat AXI4 read or write transactions on one master port of the bus.
- Stalls the core until the transaction finishes, then returns read data and the error status.
- One outstanding transaction at a time. Supports byte, half-word and word accesses.

---
 rtl/axi_core_pkg.sv | 30 +++
 rtl/axi_core_master.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_core_master.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_core_pkg.sv
// Shared types and constants for the core-to-AXI master bridge.
package axi_core_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI transfer size derived from the byte enables of a 32-bit lane group.
  function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
    logic [2:0] size;
    case (strb)
      4'b1111:                            size = 3'd2;
      4'b0011, 4'b1100:                   size = 3'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = 3'd0;
      default:                            size = 3'd2;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/axi_core_master.sv
// Core memory port to single-beat AXI4 master, one transaction outstanding.
// Optional error counter output enabled by defining AXI_CORE_MASTER_ERRCNT_EN.
module axi_core_master
  import axi_core_pkg::*;
#(
  parameter logic [3:0]  MASTER_ID = 4'h0,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned STRB_W   = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // Core side
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [1:0]        core_size,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [STRB_W-1:0] core_wstrb,
  output logic              core_stall,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  // Write address
  output logic [3:0]        AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [3:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  // Write data
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  // Write response
  input  logic [3:0]        BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // Read address
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  // Read data
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
`ifdef AXI_CORE_MASTER_ERRCNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              arvalid_q;
  logic              rready_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic              resp_valid_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;
  logic r_err;
  logic b_err;

  assign aw_hs  = awvalid_q && AWREADY;
  assign w_hs   = wvalid_q && WREADY;
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  // A mismatched ID or a missing RLAST on a single-beat read is reported as an error.
  assign r_err = (RRESP != RESP_OKAY) || !RLAST || (RID != MASTER_ID);
  assign b_err = (BRESP != RESP_OKAY) || (BID != MASTER_ID);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (core_req) begin
            addr_q  <= core_addr;
            we_q    <= core_we;
            size_q  <= core_size;
            wdata_q <= core_wdata;
            wstrb_q <= core_wstrb;
            if (core_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdAddr;
            end
          end
        end
        StRdAddr: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (RVALID) begin
            rready_q     <= 1'b0;
            rdata_q      <= (RRESP != RESP_OKAY) ? '0 : RDATA;
            err_q        <= r_err;
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StWrReq: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (BVALID) begin
            bready_q     <= 1'b0;
            rdata_q      <= '0;
            err_q        <= b_err;
            resp_valid_q <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef AXI_CORE_MASTER_ERRCNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_count_q <= 8'h00;
    end else if (resp_valid_q && err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'h01;
    end
  end

  assign err_count = err_count_q;
`endif

  // Stall drops only in the completion cycle so a held request restarts in IDLE.
  assign core_stall      = core_req && !resp_valid_q;
  assign core_resp_valid = resp_valid_q;
  assign core_rdata      = rdata_q;
  assign core_err        = err_q;

  assign ARID    = MASTER_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 4'd0;
  assign ARSIZE  = {1'b0, size_q};
  assign ARBURST = BURST_INCR;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;

  assign AWID    = MASTER_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = strb_to_size(wstrb_q[3:0]);
  assign AWBURST = BURST_INCR;
  assign AWVALID = awvalid_q;

  assign WDATA  = wdata_q;
  assign WSTRB  = wstrb_q;
  assign WLAST  = 1'b1;
  assign WVALID = wvalid_q;
  assign BREADY = bready_q;

  // we_q is kept for visibility of the accepted request type.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_axi_core_master.sv
// Directed bench for axi_core_master with a transaction-level model and AXI slave stub.
module tb_axi_core_master;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [1:0]  core_size = '0;
  logic [3:0]  core_wstrb = '0;
  logic        core_stall, core_resp_valid, core_err;
  logic [31:0] core_rdata;
  logic [3:0]  AWID, AWLEN, ARID, ARLEN;
  logic [31:0] AWADDR, ARADDR, WDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWVALID, WLAST, WVALID, BREADY, ARVALID, RREADY;
  logic [3:0]  WSTRB;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [3:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
`ifdef AXI_CORE_MASTER_ERRCNT_EN
  logic [7:0]  err_count;
  int          exp_errcnt = 0;
`endif

  axi_core_master dut (
`ifdef AXI_CORE_MASTER_ERRCNT_EN
    .err_count(err_count),
`endif
    .ACLK(ACLK), .ARESETn(ARESETn),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_size(core_size),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb), .core_stall(core_stall),
    .core_resp_valid(core_resp_valid), .core_rdata(core_rdata), .core_err(core_err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Slave configuration for the next transaction.
  int          ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  logic        s_rlast = 1'b1;
  logic [3:0]  s_rid = 4'h0, s_bid = 4'h0;

  // Handshakes that will complete at the coming rising edge.
  logic hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
  } txn_t;
  txn_t exp_q[$];

  function automatic logic [2:0] model_size(input logic [3:0] s);
    if ($countones(s) == 1) return 3'd0;
    if (s == 4'b0011 || s == 4'b1100) return 3'd1;
    return 3'd2;
  endfunction

  // AXI slave stub: READY after a programmable wait, responses one cycle after handshakes.
  initial begin
    int  ar_cnt, aw_cnt, w_cnt;
    bit  aw_seen, w_seen;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
    ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
    RDATA = '0; RRESP = '0; RLAST = 0; RID = '0; BRESP = '0; BID = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
      end else begin
        if (hs_r) RVALID = 0;
        if (hs_ar) RVALID = 1;
        if (hs_b) BVALID = 0;
        if (hs_aw) aw_seen = 1;
        if (hs_w) w_seen = 1;
        if (aw_seen && w_seen) begin
          BVALID = 1; aw_seen = 0; w_seen = 0;
        end
        ARREADY = ARVALID && (ar_cnt >= ar_delay);
        if (ARVALID && !ARREADY) ar_cnt++; else ar_cnt = 0;
        AWREADY = AWVALID && (aw_cnt >= aw_delay);
        if (AWVALID && !AWREADY) aw_cnt++; else aw_cnt = 0;
        WREADY = WVALID && (w_cnt >= w_delay);
        if (WVALID && !WREADY) w_cnt++; else w_cnt = 0;
        RDATA = s_rdata; RRESP = s_rresp; RLAST = s_rlast; RID = s_rid;
        BRESP = s_bresp; BID = s_bid;
        hs_ar = ARVALID && ARREADY;
        hs_r  = RVALID && RREADY;
        hs_aw = AWVALID && AWREADY;
        hs_w  = WVALID && WREADY;
        hs_b  = BVALID && BREADY;
      end
    end
  end

  // Compare process: checks every DUT output against the model each cycle.
  initial begin
    bit   aw_ok, w_ok;
    txn_t t;
    aw_ok = 0; w_ok = 0;
    forever begin
      @(posedge ACLK);
      #2;
      if (!ARESETn) begin
        aw_ok = 0; w_ok = 0;
`ifdef AXI_CORE_MASTER_ERRCNT_EN
        exp_errcnt = 0;
`endif
        continue;
      end
      if (hs_aw) aw_ok = 1;
      if (hs_w) w_ok = 1;
      chk("core_stall", core_stall, core_req && !core_resp_valid);
      chk("awvalid_after_hs", AWVALID && aw_ok, 0);
      chk("wvalid_after_hs", WVALID && w_ok, 0);
      chk("bready_before_both_hs", BREADY && !(aw_ok && w_ok), 0);
      if (exp_q.size() > 0) begin
        t = exp_q[0];
        if (ARVALID) begin
          chk("ar_for_read", t.we, 0);
          chk("araddr", ARADDR, t.addr);
          chk("arsize", ARSIZE, {1'b0, t.size});
          chk("arlen", ARLEN, 0);
          chk("arburst", ARBURST, 2'b01);
          chk("arid", ARID, 0);
        end
        if (AWVALID) begin
          chk("aw_for_write", t.we, 1);
          chk("awaddr", AWADDR, t.addr);
          chk("awsize", AWSIZE, model_size(t.wstrb));
          chk("awlen", AWLEN, 0);
          chk("awburst", AWBURST, 2'b01);
          chk("awid", AWID, 0);
        end
        if (WVALID) begin
          chk("wdata", WDATA, t.wdata);
          chk("wstrb", WSTRB, t.wstrb);
          chk("wlast", WLAST, 1);
        end
      end else begin
        chk("valid_without_request", ARVALID || AWVALID || WVALID, 0);
      end
`ifdef AXI_CORE_MASTER_ERRCNT_EN
      chk("err_count", err_count, exp_errcnt);
`endif
      if (core_resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          t = exp_q.pop_front();
          chk("core_rdata", core_rdata, t.rdata);
          chk("core_err", core_err, t.err);
          if (t.lat >= 0) chk("latency", cyc - t.start, t.lat);
`ifdef AXI_CORE_MASTER_ERRCNT_EN
          if (t.err && exp_errcnt < 255) exp_errcnt++;
`endif
        end
        aw_ok = 0; w_ok = 0;
      end
    end
  end

  // Issue one core request; lat is the expected resp cycle offset from the request cycle.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input int lat,
                        input bit hold, output logic [31:0] rdata, output logic err);
    txn_t t;
    bit   got;
    @(negedge ACLK);
    t.we = we; t.addr = addr; t.size = size; t.wdata = wdata; t.wstrb = wstrb;
    t.err   = we ? (s_bresp != 2'b00 || s_bid != 4'h0)
                 : (s_rresp != 2'b00 || !s_rlast || s_rid != 4'h0);
    t.rdata = (we || s_rresp != 2'b00) ? 32'h0 : s_rdata;
    t.lat = lat; t.start = cyc;
    exp_q.push_back(t);
    core_req = 1; core_we = we; core_addr = addr; core_size = size;
    core_wdata = wdata; core_wstrb = wstrb;
    got = 0; rdata = '0; err = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge ACLK);
      #1;
      if (core_resp_valid) begin
        got = 1; rdata = core_rdata; err = core_err;
      end
    end
    if (!got) begin
      chk("resp_timeout", 0, 1);
      exp_q.delete();
    end
    if (!hold) begin
      @(negedge ACLK);
      core_req = 0;
    end
  endtask

  task automatic set_slave(input int ard, input int awd, input int wd, input logic [31:0] rd,
                           input logic [1:0] rr, input logic rl, input logic [3:0] rid,
                           input logic [1:0] br, input logic [3:0] bid);
    ar_delay = ard; aw_delay = awd; w_delay = wd; s_rdata = rd; s_rresp = rr; s_rlast = rl;
    s_rid = rid; s_bresp = br; s_bid = bid;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          seen;

    #3;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_resp_valid", core_resp_valid, 0);
    chk("rst_err", core_err, 0);
    chk("rst_rdata", core_rdata, 0);
`ifdef AXI_CORE_MASTER_ERRCNT_EN
    chk("rst_err_count", err_count, 0);
`endif
    repeat (2) @(negedge ACLK);
    #3 ARESETn = 1;

    // Word read, zero wait
    set_slave(0, 0, 0, 32'hDEAD_BEEF, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    do_txn(0, 32'h0001_0004, 2'd2, 32'h0, 4'h0, 3, 0, rd, er);
    chk("word_read_rdata", rd, 32'hDEAD_BEEF);
    chk("word_read_err", er, 0);

    // Byte write, zero wait
    do_txn(1, 32'h0001_0002, 2'd0, 32'h00AB_0000, 4'b0100, 3, 0, rd, er);
    chk("byte_write_err", er, 0);

    // Half-word write, W accepted 3 cycles before AW
    set_slave(0, 3, 0, 32'h0, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    do_txn(1, 32'h0000_0020, 2'd1, 32'h1234_0000, 4'b1100, -1, 0, rd, er);
    chk("w_early_err", er, 0);

    // Read with SLVERR
    set_slave(0, 0, 0, 32'hCAFE_F00D, 2'b10, 1, 4'h0, 2'b00, 4'h0);
    do_txn(0, 32'h0000_0010, 2'd2, 32'h0, 4'h0, 3, 0, rd, er);
    chk("slverr_rdata", rd, 32'h0);
    chk("slverr_err", er, 1);
`ifdef AXI_CORE_MASTER_ERRCNT_EN
    @(posedge ACLK);
    #1 chk("err_count_after_slverr", err_count, 8'd1);
`endif

    // AW accepted before W, irregular strobe
    set_slave(0, 0, 2, 32'h0, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    do_txn(1, 32'h0000_0030, 2'd2, 32'h0055_6600, 4'b0110, -1, 0, rd, er);
    chk("aw_early_err", er, 0);

    // Read with AR wait and missing RLAST
    set_slave(2, 0, 0, 32'h1111_2222, 2'b00, 0, 4'h0, 2'b00, 4'h0);
    do_txn(0, 32'h0000_0044, 2'd1, 32'h0, 4'h0, 5, 0, rd, er);
    chk("no_rlast_err", er, 1);
    chk("no_rlast_rdata", rd, 32'h1111_2222);

    // Read with foreign RID, write with DECERR, write with foreign BID
    set_slave(0, 0, 0, 32'h3333_4444, 2'b00, 1, 4'h5, 2'b00, 4'h0);
    do_txn(0, 32'h0000_0048, 2'd0, 32'h0, 4'h0, 3, 0, rd, er);
    set_slave(0, 0, 0, 32'h0, 2'b00, 1, 4'h0, 2'b11, 4'h0);
    do_txn(1, 32'h0000_004C, 2'd2, 32'hA5A5_A5A5, 4'b1111, 3, 0, rd, er);
    chk("decerr_write_err", er, 1);
    set_slave(0, 0, 0, 32'h0, 2'b00, 1, 4'h0, 2'b00, 4'h3);
    do_txn(1, 32'h0000_0050, 2'd0, 32'h0000_00EE, 4'b0001, 3, 0, rd, er);

    // Reset while ARVALID is waiting on ARREADY
    set_slave(1000, 0, 0, 32'h0, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    begin
      txn_t t;
      @(negedge ACLK);
      t.we = 0; t.addr = 32'h0000_0060; t.size = 2'd2; t.wdata = '0; t.wstrb = '0;
      t.rdata = '0; t.err = 0; t.lat = -1; t.start = cyc;
      exp_q.push_back(t);
      core_req = 1; core_we = 0; core_addr = 32'h0000_0060; core_size = 2'd2;
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge ACLK);
      #1 seen = ARVALID;
    end
    chk("arvalid_before_reset", seen, 1);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    core_req = 0;
    #2 ARESETn = 0;
    #1 chk("arvalid_async_reset", ARVALID, 0);
    chk("resp_valid_async_reset", core_resp_valid, 0);
    exp_q.delete();
    repeat (2) @(negedge ACLK);
    #3 ARESETn = 1;
    chk("arvalid_after_release", ARVALID, 0);

    // Normal read after reset
    set_slave(0, 0, 0, 32'h5A5A_0F0F, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    do_txn(0, 32'h0000_0070, 2'd2, 32'h0, 4'h0, 3, 0, rd, er);
    chk("post_reset_rdata", rd, 32'h5A5A_0F0F);
    chk("post_reset_err", er, 0);

    // Back-to-back reads with core_req held high
    set_slave(0, 0, 0, 32'h0000_0001, 2'b00, 1, 4'h0, 2'b00, 4'h0);
    do_txn(0, 32'h0000_0100, 2'd2, 32'h0, 4'h0, 3, 1, rd, er);
    s_rdata = 32'h0000_0002;
    do_txn(0, 32'h0000_0104, 2'd2, 32'h0, 4'h0, 4, 1, rd, er);
    chk("b2b_second_rdata", rd, 32'h0000_0002);
    s_rdata = 32'h0000_0003;
    do_txn(0, 32'h0000_0108, 2'd2, 32'h0, 4'h0, 4, 0, rd, er);
    chk("b2b_third_rdata", rd, 32'h0000_0003);

    repeat (3) @(posedge ACLK);
    chk("model_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
